// File: rtl/sw_write_master.sv
// sw_write_master: buffers host (addr, data) write commands in a FIFO and replays
// each one as a single-cycle sw_we strobe framed by a 4-phase req/ack handshake.
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid/ready/addr/data host command push interface (ready = !fifo_full)
//   req, ack                 handshake toward / from the register block
//   sw_we, sw_addr, sw_wdata registered write strobe, address and data
//   fifo_full, fifo_empty    FIFO occupancy flags
//   busy                     FSM is not IDLE
//   done_cnt                 saturating count of acknowledged writes
//   err, err_clr             sticky handshake-timeout flag and its clear
module sw_write_master #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              req,
    input  logic              ack,
    output logic              sw_we,
    output logic [ADDR_W-1:0] sw_addr,
    output logic [DATA_W-1:0] sw_wdata,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              busy,
    output logic [15:0]       done_cnt,
    output logic              err,
    input  logic              err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W+DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W+DATA_W-1:0]   mem_d [DEPTH];
    logic [AW-1:0]              wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic                       req_q, req_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic [15:0]                done_q, done_d;
    logic                       push, pop, err_set;

    assign fifo_full  = cnt_q == (AW+1)'(DEPTH);
    assign fifo_empty = cnt_q == '0;
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign busy       = state_q != IDLE;
    assign req        = req_q;
    assign sw_we      = we_q;
    assign sw_addr    = addr_q;
    assign sw_wdata   = data_q;
    assign done_cnt   = done_q;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        done_d  = done_q;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    done_d  = (done_q == 16'hFFFF) ? done_q : done_q + 16'd1;
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else if (tmo_q == TMAX) begin
                    err_set = 1'b1;
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RELEASE: begin
                // A dropped ack chains straight into the next command, saving the IDLE cycle.
                if (!ack) begin
                    state_d = fifo_empty ? IDLE : ISSUE;
                    pop     = !fifo_empty;
                end else if (tmo_q == TMAX) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == ISSUE) || (state_d == WAIT_ACK);
        we_d   = state_d == ISSUE;
        addr_d = pop ? mem_q[rd_q][ADDR_W+DATA_W-1:DATA_W] : addr_q;
        data_d = pop ? mem_q[rd_q][DATA_W-1:0] : data_q;
        // A timeout in the same cycle as a clear must leave err set.
        err_d  = err_set || (err_q && !err_clr);
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        mem_d  = mem_q;
        if (push) mem_d[wr_q] = {cmd_addr, cmd_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
